// File: rtl/edge_event_arbiter_pkg.sv
// Shared constants and helpers for the edge event arbiter.
// The optional timestamp path is controlled by the EDGE_ARB_TIMESTAMP_EN macro.
package edge_event_arbiter_pkg;

    localparam logic EDGE_RISE    = 1'b1;
    localparam logic EDGE_FALL    = 1'b0;
    localparam int   TS_W_DEFAULT = 16;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } out_state_e;

    // Number of bits needed to index v entries (v >= 2).
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/edge_arb_chan.sv
// One level channel: dual-edge detection and a single-entry pending event slot.
// Captures a timestamp with each edge when EDGE_ARB_TIMESTAMP_EN is defined.
module edge_arb_chan
    import edge_event_arbiter_pkg::*;
#(
    parameter int TS_W = TS_W_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            level_i,
    input  logic            load_i,
    input  logic            clr_ovf,
`ifdef EDGE_ARB_TIMESTAMP_EN
    input  logic [TS_W-1:0] ts_i,
    output logic [TS_W-1:0] ts_o,
`endif
    output logic            pending_o,
    output logic            pol_o,
    output logic            ovf_o
);

    logic level_q, level_d;
    logic pending_q, pending_d;
    logic pol_q, pol_d;
    logic ovf_q, ovf_d;
    logic edge_det, rise_det;

`ifdef EDGE_ARB_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q, ts_d;
`endif

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        level_d   = level_i;
        pending_d = pending_q;
        pol_d     = pol_q;
        ovf_d     = clr_ovf ? 1'b0 : ovf_q;
`ifdef EDGE_ARB_TIMESTAMP_EN
        ts_d      = ts_q;
`endif
        edge_det  = level_i ^ level_q;
        rise_det  = level_i & ~level_q;

        if (load_i) pending_d = 1'b0;

        // A new edge re-arms the slot even in its load cycle; it only counts as
        // lost when the previous event is still waiting for a grant.
        if (edge_det) begin
            pending_d = 1'b1;
            pol_d     = rise_det ? EDGE_RISE : EDGE_FALL;
`ifdef EDGE_ARB_TIMESTAMP_EN
            ts_d      = ts_i;
`endif
            if (pending_q && !load_i) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level_q   <= 1'b0;
            pending_q <= 1'b0;
            pol_q     <= 1'b0;
            ovf_q     <= 1'b0;
`ifdef EDGE_ARB_TIMESTAMP_EN
            ts_q      <= '0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            level_q   <= level_d;
            pending_q <= pending_d;
            pol_q     <= pol_d;
            ovf_q     <= ovf_d;
`ifdef EDGE_ARB_TIMESTAMP_EN
            ts_q      <= ts_d;
`endif
        end
    end

    assign pending_o = pending_q;
    assign pol_o     = pol_q;
    assign ovf_o     = ovf_q;
`ifdef EDGE_ARB_TIMESTAMP_EN
    assign ts_o      = ts_q;
`endif

endmodule

// File: rtl/edge_event_arbiter.sv
// Round-robin arbiter of per-channel edge events onto one valid/ready stream.
// Defining EDGE_ARB_TIMESTAMP_EN adds a free-running counter and the evt_ts output.
module edge_event_arbiter
    import edge_event_arbiter_pkg::*;
#(
    parameter int N    = 4,
    parameter int ID_W = 2,
    parameter int TS_W = TS_W_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    level,
    output logic            evt_valid,
    input  logic            evt_ready,
    output logic [ID_W-1:0] evt_ch,
    output logic            evt_rise,
`ifdef EDGE_ARB_TIMESTAMP_EN
    output logic [TS_W-1:0] evt_ts,
`endif
    output logic [N-1:0]    overflow,
    input  logic            clr_ovf
);

    if (ID_W != clog2(N)) begin : g_bad_id_w
        $error("edge_event_arbiter: ID_W must equal clog2(N)");
    end

    out_state_e      state_q, state_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W-1:0] evt_ch_q, evt_ch_d;
    logic            evt_rise_q, evt_rise_d;

    logic [N-1:0]    pend_vec;
    logic [N-1:0]    pol_vec;
    logic [N-1:0]    load_vec;
    logic [ID_W-1:0] grant;
    logic            found;
    logic            do_load;
    int              idx;

`ifdef EDGE_ARB_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt_q, ts_cnt_d;
    logic [TS_W-1:0] evt_ts_q, evt_ts_d;
    logic [TS_W-1:0] ts_vec [N];
`endif

    for (genvar i = 0; i < N; i++) begin : g_chan
        edge_arb_chan #(.TS_W(TS_W)) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .level_i   (level[i]),
            .load_i    (load_vec[i]),
            .clr_ovf   (clr_ovf),
`ifdef EDGE_ARB_TIMESTAMP_EN
            .ts_i      (ts_cnt_q),
            .ts_o      (ts_vec[i]),
`endif
            .pending_o (pend_vec[i]),
            .pol_o     (pol_vec[i]),
            .ovf_o     (overflow[i])
        );
    end

    // Search starts one past the last grant so every channel gets a turn.
    always_comb begin
        grant = ptr_q;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr_q) + k) % N;
            if (!found && pend_vec[idx]) begin
                found = 1'b1;
                grant = ID_W'(idx);
            end
        end
    end

    always_comb begin
        do_load    = ((state_q == S_EMPTY) || evt_ready) && found;
        state_d    = state_q;
        ptr_d      = ptr_q;
        evt_ch_d   = evt_ch_q;
        evt_rise_d = evt_rise_q;
        load_vec   = '0;
`ifdef EDGE_ARB_TIMESTAMP_EN
        ts_cnt_d   = ts_cnt_q + TS_W'(1);
        evt_ts_d   = evt_ts_q;
`endif

        if (do_load) begin
            state_d         = S_FULL;
            ptr_d           = grant;
            evt_ch_d        = grant;
            evt_rise_d      = pol_vec[grant];
            load_vec[grant] = 1'b1;
`ifdef EDGE_ARB_TIMESTAMP_EN
            evt_ts_d        = ts_vec[grant];
`endif
        end else if ((state_q == S_FULL) && evt_ready) begin
            state_d = S_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_EMPTY;
            ptr_q      <= ID_W'(N - 1);
            evt_ch_q   <= '0;
            evt_rise_q <= 1'b0;
`ifdef EDGE_ARB_TIMESTAMP_EN
            ts_cnt_q   <= '0;
            evt_ts_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            evt_ch_q   <= evt_ch_d;
            evt_rise_q <= evt_rise_d;
`ifdef EDGE_ARB_TIMESTAMP_EN
            ts_cnt_q   <= ts_cnt_d;
            evt_ts_q   <= evt_ts_d;
`endif
        end
    end

    assign evt_valid = (state_q == S_FULL);
    assign evt_ch    = evt_ch_q;
    assign evt_rise  = evt_rise_q;
`ifdef EDGE_ARB_TIMESTAMP_EN
    assign evt_ts    = evt_ts_q;
`endif

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed self-checking bench for edge_event_arbiter (N=4).
// Timestamp checks are compiled in when EDGE_ARB_TIMESTAMP_EN is defined.
module tb_edge_event_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  level;
    logic        evt_valid;
    logic        evt_ready;
    logic [1:0]  evt_ch;
    logic        evt_rise;
    logic [3:0]  overflow;
    logic        clr_ovf;
`ifdef EDGE_ARB_TIMESTAMP_EN
    logic [15:0] evt_ts;
`endif

    int n_cmp;
    int n_err;

    edge_event_arbiter #(.N(4), .ID_W(2), .TS_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .level     (level),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_ch    (evt_ch),
        .evt_rise  (evt_rise),
`ifdef EDGE_ARB_TIMESTAMP_EN
        .evt_ts    (evt_ts),
`endif
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_evt(input string tag, input logic v, input logic [1:0] ch, input logic r);
        check({tag, ".valid"}, 32'(evt_valid), 32'(v));
        if (v) begin
            check({tag, ".ch"},   32'(evt_ch),   32'(ch));
            check({tag, ".rise"}, 32'(evt_rise), 32'(r));
        end
    endtask

    task automatic do_reset(input logic [3:0] lvl);
        rst_n     = 1'b0;
        level     = lvl;
        evt_ready = 1'b1;
        clr_ovf   = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;

        // Reset state, level low
        rst_n = 1'b0; level = '0; evt_ready = 1'b1; clr_ovf = 1'b0;
        step(3);
        check_evt("rst", 1'b0, 2'd0, 1'b0);
        check("rst.ovf", 32'(overflow), 32'h0);
        rst_n = 1'b1;
        step(2);
        check_evt("rst_idle", 1'b0, 2'd0, 1'b0);

        // One-cycle pulse on ch0: rise then fall on consecutive cycles
        level = 4'b0001;
        step(1);
        check_evt("p0.t1", 1'b0, 2'd0, 1'b0);
        level = 4'b0000;
        step(1);
        check_evt("p0.rise", 1'b1, 2'd0, 1'b1);
        step(1);
        check_evt("p0.fall", 1'b1, 2'd0, 1'b0);
        step(1);
        check_evt("p0.empty", 1'b0, 2'd0, 1'b0);

        // Three channels rise together from ptr=N-1
        do_reset(4'b0000);
        level = 4'b1110;
        step(1);
        step(1);
        check_evt("rr.ch1", 1'b1, 2'd1, 1'b1);
        step(1);
        check_evt("rr.ch2", 1'b1, 2'd2, 1'b1);
        step(1);
        check_evt("rr.ch3", 1'b1, 2'd3, 1'b1);
        check("rr.ptr", 32'(dut.ptr_q), 32'd3);
        step(1);
        check_evt("rr.empty", 1'b0, 2'd0, 1'b0);

        // Backpressure with toggling ch2 -> overflow, then drain and clear
        do_reset(4'b0000);
        evt_ready = 1'b0;
        level = 4'b0100;
        step(1);
        level = 4'b0000;
        step(1);
        check_evt("bp.load", 1'b1, 2'd2, 1'b1);
        check("bp.ovf0", 32'(overflow), 32'h0);
        level = 4'b0100;
        step(1);
        check_evt("bp.hold1", 1'b1, 2'd2, 1'b1);
        check("bp.ovf1", 32'(overflow), 32'h4);
        step(1);
        check_evt("bp.hold2", 1'b1, 2'd2, 1'b1);
        evt_ready = 1'b1;
        step(1);
        check_evt("bp.second", 1'b1, 2'd2, 1'b1);
        step(1);
        check_evt("bp.empty", 1'b0, 2'd0, 1'b0);
        check("bp.ovf_sticky", 32'(overflow), 32'h4);
        clr_ovf = 1'b1;
        step(1);
        clr_ovf = 1'b0;
        check("bp.ovf_clr", 32'(overflow), 32'h0);

        // Edge in load cycle does not overflow; set beats a simultaneous clear
        evt_ready = 1'b0;
        level = 4'b0110;
        step(1);
        level = 4'b0100;
        step(1);
        check_evt("sw.load", 1'b1, 2'd1, 1'b1);
        check("sw.no_ovf", 32'(overflow), 32'h0);
        level = 4'b0110;
        clr_ovf = 1'b1;
        step(1);
        clr_ovf = 1'b0;
        check("sw.set_wins", 32'(overflow), 32'h2);
        evt_ready = 1'b1;
        step(1);
        check_evt("sw.drain", 1'b1, 2'd1, 1'b1);
        step(1);
        check_evt("sw.empty", 1'b0, 2'd0, 1'b0);

        // Reset mid-stream with two pending channels
        do_reset(4'b0000);
        evt_ready = 1'b0;
        level = 4'b1001;
        step(1);
        rst_n = 1'b0;
        level = 4'b0000;
        step(1);
        rst_n = 1'b1;
        check_evt("mr.rst", 1'b0, 2'd0, 1'b0);
        evt_ready = 1'b1;
        step(1);
        check_evt("mr.t1", 1'b0, 2'd0, 1'b0);
        step(1);
        check_evt("mr.t2", 1'b0, 2'd0, 1'b0);

        // Channel held high through reset release reports one rising event
        do_reset(4'b0010);
        step(1);
        step(1);
        check_evt("hh.rise", 1'b1, 2'd1, 1'b1);
        step(1);
        check_evt("hh.empty", 1'b0, 2'd0, 1'b0);

`ifdef EDGE_ARB_TIMESTAMP_EN
        // Edge sampled when the counter reads 5; timestamp held under backpressure
        do_reset(4'b0000);
        evt_ready = 1'b0;
        step(5);
        level = 4'b0010;
        step(1);
        step(1);
        check_evt("ts.evt", 1'b1, 2'd1, 1'b1);
        check("ts.val", 32'(evt_ts), 32'd5);
        step(1);
        check("ts.hold", 32'(evt_ts), 32'd5);
        evt_ready = 1'b1;
        step(1);
        check_evt("ts.empty", 1'b0, 2'd0, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
